// File: rtl/cfg_loader.sv
// cfg_loader: serializes configuration words MSB-first onto the CLB scan chain,
//   counting exactly CHAIN_LEN shift cycles, then holds in DONE until the next start.
// Latency: start -> FETCH next cycle; handshake -> first bit on scan_out next cycle;
//   full load = CHAIN_LEN + ceil(CHAIN_LEN/WORD_WIDTH) cycles from the first FETCH.
// Backpressure: cfg_ready is high only in FETCH; a stall parks in FETCH with scan_en low.
//
// Ports: clk/reset (async active-high); start; cfg_data/cfg_valid/cfg_ready word input;
//   scan_en/scan_out to the chain head; scan_in from the chain tail (readback only);
//   busy/done/error status.
// Optional feature: define CFG_LOADER_READBACK_EN to recirculate the chain once after the
//   load and compare its parity with the parity of the bits shifted in.
module cfg_loader #(
    parameter int WORD_WIDTH = 8,
    parameter int CHAIN_LEN  = 29,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  scan_en,
    output logic                  scan_out,
    input  logic                  scan_in,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int WB_W = $clog2(WORD_WIDTH) + 1;

`ifdef CFG_LOADER_READBACK_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_VERIFY, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_t;
`endif

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WB_W-1:0]       wbit_q, wbit_d;
    logic                  par_q, par_d;
    logic                  last_bit;
    logic                  word_end;
    logic                  restart;

    // bit_cnt counts the current phase (load, then verify); it is zeroed on the
    // final load bit so the verify pass reuses it.
    assign last_bit = (bit_cnt_q == CNT_WIDTH'(CHAIN_LEN - 1));
    assign word_end = (wbit_q == WB_W'(WORD_WIDTH - 1));
    assign restart  = start && (state_q == S_IDLE || state_q == S_DONE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; the chain-length check wins over the word boundary so a
    // partial final word is cut short.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start)     state_d = S_FETCH;
            S_FETCH:        if (cfg_valid) state_d = S_SHIFT;
            S_SHIFT: begin
                if (last_bit) begin
`ifdef CFG_LOADER_READBACK_EN
                    state_d = S_VERIFY;
`else
                    state_d = S_DONE;
`endif
                end else if (word_end) begin
                    state_d = S_FETCH;
                end
            end
`ifdef CFG_LOADER_READBACK_EN
            S_VERIFY:       if (last_bit)  state_d = S_DONE;
`endif
            default:        state_d = S_IDLE;
        endcase
    end

    // Datapath
    always_comb begin
        word_d    = word_q;
        bit_cnt_d = bit_cnt_q;
        wbit_d    = wbit_q;
        par_d     = par_q;
        if (restart) begin
            bit_cnt_d = '0;
            wbit_d    = '0;
            par_d     = 1'b0;
        end else if (state_q == S_FETCH && cfg_valid) begin
            word_d = cfg_data;
            wbit_d = '0;
        end else if (state_q == S_SHIFT) begin
            word_d    = word_q << 1;
            wbit_d    = wbit_q + WB_W'(1);
            par_d     = par_q ^ word_q[WORD_WIDTH-1];
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + CNT_WIDTH'(1);
        end
`ifdef CFG_LOADER_READBACK_EN
        else if (state_q == S_VERIFY) begin
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + CNT_WIDTH'(1);
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q    <= '0;
            bit_cnt_q <= '0;
            wbit_q    <= '0;
            par_q     <= 1'b0;
        end else begin
            word_q    <= word_d;
            bit_cnt_q <= bit_cnt_d;
            wbit_q    <= wbit_d;
            par_q     <= par_d;
        end
    end

`ifdef CFG_LOADER_READBACK_EN
    logic chk_par_q, chk_par_d;
    logic error_q, error_d;

    always_comb begin
        chk_par_d = chk_par_q;
        error_d   = error_q;
        if (restart) begin
            chk_par_d = 1'b0;
            error_d   = 1'b0;
        end else if (state_q == S_VERIFY) begin
            chk_par_d = chk_par_q ^ scan_in;
            if (last_bit && ((chk_par_q ^ scan_in) != par_q)) error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_par_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            chk_par_q <= chk_par_d;
            error_q   <= error_d;
        end
    end

    assign error = error_q;
`else
    logic unused_scan_in;
    assign unused_scan_in = scan_in;
    assign error          = 1'b0;
`endif

    // Outputs decode flopped state/word only, so the chain sees stable values and
    // an async reset drops scan_en at once. In verify the chain tail feeds its head
    // directly; the tail is a flop so there is no combinational loop.
    always_comb begin
        cfg_ready = (state_q == S_FETCH);
        busy      = (state_q == S_FETCH) || (state_q == S_SHIFT);
        done      = (state_q == S_DONE);
        scan_en   = (state_q == S_SHIFT);
        scan_out  = (state_q == S_SHIFT) ? word_q[WORD_WIDTH-1] : 1'b0;
`ifdef CFG_LOADER_READBACK_EN
        if (state_q == S_VERIFY) begin
            busy     = 1'b1;
            scan_en  = 1'b1;
            scan_out = scan_in;
        end
`endif
    end

endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader: directed bench for cfg_loader with a default (29-bit) instance and a
//   32-bit chain instance sharing the same word stream.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_cfg_loader;

`ifdef CFG_LOADER_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic       clk;
    logic       reset;
    logic       start;
    logic       cfg_valid;
    logic [7:0] cfg_data;
    logic       a_ready, a_en, a_out, a_in, a_busy, a_done, a_err;
    logic       b_ready, b_en, b_out, b_in, b_busy, b_done, b_err;

    cfg_loader dut (
        .clk(clk), .reset(reset), .start(start), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(a_ready), .scan_en(a_en), .scan_out(a_out),
        .scan_in(a_in), .busy(a_busy), .done(a_done), .error(a_err)
    );

    cfg_loader #(.WORD_WIDTH(8), .CHAIN_LEN(32), .CNT_WIDTH(16)) dut32 (
        .clk(clk), .reset(reset), .start(start), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(b_ready), .scan_en(b_en), .scan_out(b_out),
        .scan_in(b_in), .busy(b_busy), .done(b_done), .error(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CFG_LOADER_READBACK_EN
    // Chain models: shift on scan_en, tail is the last flop; inject inverts the tail.
    logic        inject;
    logic [28:0] chain_a;
    logic [31:0] chain_b;
    always @(posedge clk) begin
        if (reset) begin
            chain_a <= '0;
            chain_b <= '0;
        end else begin
            if (a_en) chain_a <= {chain_a[27:0], a_out};
            if (b_en) chain_b <= {chain_b[30:0], b_out};
        end
    end
    assign a_in = chain_a[28] ^ inject;
    assign b_in = chain_b[31];
`else
    assign a_in = 1'b0;
    assign b_in = 1'b0;
`endif

    // Monitor
    logic        mon_clr;
    logic [28:0] stream_a;
    logic [31:0] stream_b;
    int          en_a, en_b, hs_a, hs_b, t_a, done_t;
    logic        started, done_seen;

    always @(negedge clk) begin
        if (mon_clr) begin
            stream_a  <= '0;
            stream_b  <= '0;
            en_a      <= 0;
            en_b      <= 0;
            hs_a      <= 0;
            hs_b      <= 0;
            t_a       <= 0;
            done_t    <= -1;
            started   <= 1'b0;
            done_seen <= 1'b0;
        end else begin
            if (a_en) begin
                if (en_a < 29) stream_a <= {stream_a[27:0], a_out};
                en_a <= en_a + 1;
            end
            if (b_en) begin
                if (en_b < 32) stream_b <= {stream_b[30:0], b_out};
                en_b <= en_b + 1;
            end
            if (cfg_valid && a_ready) hs_a <= hs_a + 1;
            if (cfg_valid && b_ready) hs_b <= hs_b + 1;
            if (!started && a_ready) begin
                started <= 1'b1;
                t_a     <= 0;
            end else if (started && !done_seen) begin
                t_a <= t_a + 1;
                if (a_done) begin
                    done_seen <= 1'b1;
                    done_t    <= t_a + 1;
                end
            end
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int to_cnt = 0;
    int gap_bad;

    logic [7:0] words [4] = '{8'hA5, 8'h3C, 8'hF0, 8'hE8};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word, wait (bounded) for acceptance, then leave cfg_valid at hold.
    task automatic feed_word(input logic [7:0] w, input logic hold);
        int g;
        cfg_data  = w;
        cfg_valid = 1'b1;
        g = 0;
        while (!a_ready && g < 200) begin
            tick();
            g++;
        end
        if (g >= 200) to_cnt++;
        tick();
        cfg_valid = hold;
    endtask

    task automatic run_load(input int gap, input logic start_mid);
        int g;
        gap_bad = 0;
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 2 && gap > 0) begin
                g = 0;
                while (!a_ready && g < 200) begin
                    tick();
                    g++;
                end
                if (g >= 200) to_cnt++;
                repeat (gap) begin
                    if (a_en) gap_bad++;
                    tick();
                end
            end
            feed_word(words[k], (k < 3) && !(k == 1 && gap > 0));
            if (k == 0 && start_mid) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        g = 0;
        while (!a_done && g < 300) begin
            tick();
            g++;
        end
        if (g >= 300) to_cnt++;
        repeat (10 + RB * 32) tick();
    endtask

    task automatic check_load(input string tag, input int exp_t);
        check({tag, "_stream29"}, stream_a, 29'h14A79E1D);
        check({tag, "_en29"},     en_a, 29 * (1 + RB));
        check({tag, "_hs29"},     hs_a, 4);
        check({tag, "_done_t"},   done_t, exp_t);
        check({tag, "_done"},     {a_done, a_busy}, 2'b10);
        check({tag, "_err"},      a_err, 1'b0);
        check({tag, "_stream32"}, stream_b, 32'hA53CF0E8);
        check({tag, "_en32"},     en_b, 32 * (1 + RB));
        check({tag, "_hs32"},     hs_b, 4);
        check({tag, "_timeouts"}, to_cnt, 0);
    endtask

    initial begin
        int g;
        reset     = 1'b1;
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        mon_clr   = 1'b1;
`ifdef CFG_LOADER_READBACK_EN
        inject    = 1'b0;
`endif
        repeat (3) tick();
        check("rst_outs", {a_ready, a_en, a_out, a_busy, a_done, a_err}, 6'b0);
        check("rst_outs32", {b_ready, b_en, b_out, b_busy, b_done, b_err}, 6'b0);
        reset = 1'b0;
        tick();
        mon_clr = 1'b0;

        // cfg_valid while idle consumes nothing
        cfg_data  = 8'hFF;
        cfg_valid = 1'b1;
        repeat (3) tick();
        cfg_valid = 1'b0;
        check("idle_valid_hs", hs_a, 0);
        check("idle_valid_state", {a_busy, a_ready, a_en, a_done}, 4'b0);

        // Plain load with cfg_valid held high
        run_load(0, 1'b0);
        check_load("t1", 33 + RB * 29);

        // Five-cycle stall between words 2 and 3
        run_load(5, 1'b0);
        check("t2_gap_scan_en", gap_bad, 0);
        check_load("t2", 38 + RB * 29);

        // start pulsed mid-shift is ignored
        run_load(0, 1'b1);
        check_load("t3", 33 + RB * 29);

        // Reset in the middle of the load
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        feed_word(words[0], 1'b1);
        feed_word(words[1], 1'b1);
        g = 0;
        while (en_a < 12 && g < 100) begin
            tick();
            g++;
        end
        check("t4_mid_shift", {a_en, a_busy}, 2'b11);
        reset = 1'b1;
        #1;
        check("t4_rst_en", a_en, 1'b0);
        check("t4_rst_state", {a_busy, a_ready, a_done}, 3'b0);
        cfg_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        run_load(0, 1'b0);
        check_load("t4", 33 + RB * 29);

`ifdef CFG_LOADER_READBACK_EN
        check("rb_chain29", chain_a, 29'h14A79E1D);
        check("rb_chain32", chain_b, 32'hA53CF0E8);
        inject = 1'b1;
        run_load(0, 1'b0);
        inject = 1'b0;
        check("rb_inject_err", {a_done, a_err}, 2'b11);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rb_err_clear", {a_busy, a_err}, 2'b10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
